// File: rtl/axil_conf_regfile_nch_pkg.sv
// Shared types and constants for the multi-channel AXI-Lite configuration register file.
package conf_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [5:0] REG_CTRL      = 6'd0;
  localparam logic [5:0] REG_PERF      = 6'd63;
  localparam int         CH_STRIDE_LG2 = 8;

  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_RESP}         r_state_t;
  typedef enum logic [1:0] {CH_IDLE, CH_PEND, CH_BUSY} ch_state_t;

  function automatic logic [31:0] strb_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] strb);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++)
      if (strb[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
    return res;
  endfunction
endpackage

// File: rtl/axil_conf_regfile_nch_if.sv
// AXI4-Lite slave bundle (no ID/PROT) between the GP-port interconnect and the register file.
interface axil_conf_regfile_nch_if;
  logic [31:0] ARADDR;
  logic        ARVALID, ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID, RREADY;
  logic [31:0] AWADDR;
  logic        AWVALID, AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID, WREADY;
  logic [1:0]  BRESP;
  logic        BVALID, BREADY;

  modport slave (
    input  ARADDR, ARVALID, RREADY, AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    output ARREADY, RDATA, RRESP, RVALID, AWREADY, WREADY, BRESP, BVALID
  );
  modport master (
    output ARADDR, ARVALID, RREADY, AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    input  ARREADY, RDATA, RRESP, RVALID, AWREADY, WREADY, BRESP, BVALID
  );
endinterface

// File: rtl/axil_conf_regfile_nch_channel.sv
// Per-channel launch/handshake FSM with pending/busy/done status.
// CONF_PERF_CNT_EN adds a saturating PEND+BUSY cycle counter.
module conf_channel
  import conf_pkg::*;
(
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        launch,
  input  logic        clr_done,
  input  logic        cfg_ready,
  output logic        cfg_valid,
  output logic        pending,
  output logic        busy,
`ifdef CONF_PERF_CNT_EN
  output logic [31:0] perf,
`endif
  output logic        done
);
  ch_state_t st, nxt;
  logic      set_done;

  always_ff @(posedge ACLK)
    if (!ARESETN) st <= CH_IDLE;
    else          st <= nxt;

  always_comb begin
    nxt      = st;
    set_done = 1'b0;
    case (st)
      CH_IDLE: if (launch) nxt = CH_PEND;
      CH_PEND: if (cfg_ready) nxt = CH_BUSY;
      CH_BUSY: if (cfg_ready) begin
        nxt      = CH_IDLE;
        set_done = 1'b1;
      end
      default: nxt = CH_IDLE;
    endcase
  end

  // completion in the same cycle as a software clear keeps done set
  always_ff @(posedge ACLK)
    if (!ARESETN)      done <= 1'b0;
    else if (set_done) done <= 1'b1;
    else if (clr_done) done <= 1'b0;

  assign cfg_valid = (st == CH_PEND);
  assign pending   = (st == CH_PEND);
  assign busy      = (st == CH_BUSY);

`ifdef CONF_PERF_CNT_EN
  always_ff @(posedge ACLK)
    if (!ARESETN)                                 perf <= '0;
    else if (launch)                              perf <= '0;
    else if (st != CH_IDLE && perf != '1)         perf <= perf + 32'd1;
`endif
endmodule

// File: rtl/axil_conf_regfile_nch.sv
// AXI4-Lite configuration register file for NCH accelerator channels.
// Optional per-channel cycle counter at reg 63 under CONF_PERF_CNT_EN.
module axil_conf_regfile_nch
  import conf_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h0,
  parameter int          AW        = 12,
  parameter int          NCH       = 2,
  parameter int          NREG      = 4
) (
  input  logic                         ACLK,
  input  logic                         ARESETN,
  axil_conf_regfile_nch_if.slave       S_AXI,
  output logic [NCH-1:0]               CONFIG_VALID,
  input  logic [NCH-1:0]               CONFIG_READY,
  output logic [NCH*(NREG-1)*32-1:0]   CONFIG_DATA,
  output logic                         CONFIG_IRQ
);
  localparam int             CW     = AW - CH_STRIDE_LG2;
  localparam logic [CW:0]    NCH_L  = (CW+1)'(NCH);
  localparam logic [6:0]     NREG_L = 7'(NREG);

  logic [NCH-1:0][NREG-1:1][31:0] dreg;
  logic [NCH-1:0]                 pend, busy, done, launch, clr;
`ifdef CONF_PERF_CNT_EN
  logic [NCH-1:0][31:0]           perf;
`endif

  // ---------------- write path ----------------
  w_state_t    w_st, w_nxt;
  logic        have_aw, have_w, awready, wready, commit;
  logic [31:0] aw_q, w_q, cm_addr, cm_data;
  logic [3:0]  strb_q, cm_strb;
  logic [1:0]  bresp_q, bresp_nxt;
  logic [CW-1:0] cm_ch;
  logic [5:0]  cm_rg;
  logic        cm_ok, ctrl_wr, sel_act, launch_req;

  always_comb begin
    w_nxt   = w_st;
    awready = 1'b0;
    wready  = 1'b0;
    commit  = 1'b0;
    case (w_st)
      W_IDLE: begin
        awready = 1'b1;
        wready  = 1'b1;
        if (S_AXI.AWVALID && S_AXI.WVALID) begin
          commit = 1'b1;
          w_nxt  = W_RESP;
        end else if (S_AXI.AWVALID || S_AXI.WVALID) w_nxt = W_WAIT;
      end
      W_WAIT: begin
        awready = !have_aw;
        wready  = !have_w;
        if ((have_aw || S_AXI.AWVALID) && (have_w || S_AXI.WVALID)) begin
          commit = 1'b1;
          w_nxt  = W_RESP;
        end
      end
      W_RESP:  if (S_AXI.BREADY) w_nxt = W_IDLE;
      default: w_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK)
    if (!ARESETN) begin
      w_st    <= W_IDLE;
      have_aw <= 1'b0;
      have_w  <= 1'b0;
      aw_q    <= '0;
      w_q     <= '0;
      strb_q  <= '0;
      bresp_q <= RESP_OKAY;
    end else begin
      w_st <= w_nxt;
      if (awready && S_AXI.AWVALID) aw_q <= S_AXI.AWADDR;
      if (wready && S_AXI.WVALID) begin
        w_q    <= S_AXI.WDATA;
        strb_q <= S_AXI.WSTRB;
      end
      if (commit) begin
        have_aw <= 1'b0;
        have_w  <= 1'b0;
        bresp_q <= bresp_nxt;
      end else begin
        if (awready && S_AXI.AWVALID) have_aw <= 1'b1;
        if (wready && S_AXI.WVALID)   have_w  <= 1'b1;
      end
    end

  // the half still on the bus is used directly in the commit cycle
  assign cm_addr = have_aw ? aw_q : S_AXI.AWADDR;
  assign cm_data = have_w ? w_q : S_AXI.WDATA;
  assign cm_strb = have_w ? strb_q : S_AXI.WSTRB;
  assign cm_ch   = cm_addr[AW-1:CH_STRIDE_LG2];
  assign cm_rg   = cm_addr[7:2];
  assign cm_ok   = (cm_addr[31:AW] == ADDR_BASE[31:AW]) && ({1'b0, cm_ch} < NCH_L) &&
                   ({1'b0, cm_rg} < NREG_L);
  assign ctrl_wr    = commit && cm_ok && (cm_rg == REG_CTRL) && cm_strb[0];
  assign launch_req = ctrl_wr && cm_data[0];

  always_comb begin
    sel_act = 1'b0;
    for (int c = 0; c < NCH; c++)
      if (cm_ch == CW'(c)) sel_act = pend[c] | busy[c];
  end

  always_comb begin
    launch = '0;
    clr    = '0;
    for (int c = 0; c < NCH; c++)
      if (cm_ch == CW'(c)) begin
        launch[c] = launch_req && !sel_act;
        clr[c]    = ctrl_wr && cm_data[1];
      end
  end

  assign bresp_nxt = (!cm_ok || (launch_req && sel_act)) ? RESP_SLVERR : RESP_OKAY;

  always_ff @(posedge ACLK)
    if (!ARESETN) dreg <= '0;
    else if (commit && cm_ok && cm_rg != REG_CTRL)
      for (int c = 0; c < NCH; c++)
        for (int r = 1; r < NREG; r++)
          if (cm_ch == CW'(c) && cm_rg == 6'(r))
            dreg[c][r] <= strb_merge(dreg[c][r], cm_data, cm_strb);

  assign S_AXI.AWREADY = awready;
  assign S_AXI.WREADY  = wready;
  assign S_AXI.BVALID  = (w_st == W_RESP);
  assign S_AXI.BRESP   = bresp_q;

  // ---------------- read path ----------------
  r_state_t      r_st, r_nxt;
  logic [CW-1:0] rd_ch;
  logic [5:0]    rd_rg;
  logic          rd_ok;
  logic [31:0]   rd_val, rdata_q;
  logic [1:0]    rresp_q;

  assign rd_ch = S_AXI.ARADDR[AW-1:CH_STRIDE_LG2];
  assign rd_rg = S_AXI.ARADDR[7:2];
  assign rd_ok = (S_AXI.ARADDR[31:AW] == ADDR_BASE[31:AW]) && ({1'b0, rd_ch} < NCH_L) &&
                 (({1'b0, rd_rg} < NREG_L)
`ifdef CONF_PERF_CNT_EN
                  || (rd_rg == REG_PERF)
`endif
                 );

  always_comb begin
    rd_val = '0;
    for (int c = 0; c < NCH; c++)
      if (rd_ch == CW'(c)) begin
        if (rd_rg == REG_CTRL) rd_val = {29'b0, done[c], busy[c], pend[c]};
        for (int r = 1; r < NREG; r++)
          if (rd_rg == 6'(r)) rd_val = dreg[c][r];
`ifdef CONF_PERF_CNT_EN
        if (rd_rg == REG_PERF) rd_val = perf[c];
`endif
      end
    if (!rd_ok) rd_val = '0;
  end

  always_comb begin
    r_nxt = r_st;
    case (r_st)
      R_IDLE:  if (S_AXI.ARVALID) r_nxt = R_RESP;
      R_RESP:  if (S_AXI.RREADY)  r_nxt = R_IDLE;
      default: r_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK)
    if (!ARESETN) begin
      r_st    <= R_IDLE;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else begin
      r_st <= r_nxt;
      if (r_st == R_IDLE && S_AXI.ARVALID) begin
        rdata_q <= rd_val;
        rresp_q <= rd_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end

  assign S_AXI.ARREADY = (r_st == R_IDLE);
  assign S_AXI.RVALID  = (r_st == R_RESP);
  assign S_AXI.RDATA   = rdata_q;
  assign S_AXI.RRESP   = rresp_q;

  logic unused_addr;
  assign unused_addr = ^{cm_addr[1:0], S_AXI.ARADDR[1:0]};

  // ---------------- channels ----------------
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    conf_channel u_ch (
      .ACLK      (ACLK),
      .ARESETN   (ARESETN),
      .launch    (launch[c]),
      .clr_done  (clr[c]),
      .cfg_ready (CONFIG_READY[c]),
      .cfg_valid (CONFIG_VALID[c]),
      .pending   (pend[c]),
      .busy      (busy[c]),
`ifdef CONF_PERF_CNT_EN
      .perf      (perf[c]),
`endif
      .done      (done[c])
    );
    for (genvar r = 1; r < NREG; r++) begin : g_pk
      assign CONFIG_DATA[(c*(NREG-1)+r-1)*32 +: 32] = dreg[c][r];
    end
  end

  assign CONFIG_IRQ = |done;
endmodule

// File: tb/tb_axil_conf_regfile_nch.sv
// Scoreboard bench for axil_conf_regfile_nch: expected B/R responses are queued at issue
// and checked by a monitor on handshake; CONF_PERF_CNT_EN selects the counter scenario.
module tb_axil_conf_regfile_nch;
  import conf_pkg::*;

  logic         ACLK, ARESETN;
  logic [1:0]   CONFIG_VALID, CONFIG_READY;
  logic [191:0] CONFIG_DATA;
  logic         CONFIG_IRQ;

  axil_conf_regfile_nch_if S_AXI();

  axil_conf_regfile_nch #(.ADDR_BASE(32'h0), .AW(12), .NCH(2), .NREG(4)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .S_AXI(S_AXI),
    .CONFIG_VALID(CONFIG_VALID), .CONFIG_READY(CONFIG_READY),
    .CONFIG_DATA(CONFIG_DATA), .CONFIG_IRQ(CONFIG_IRQ)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  typedef struct { logic [1:0] resp; logic [31:0] data; } rexp_t;
  logic [1:0] bq[$];
  rexp_t      rq[$];
  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    checks++;
    errors++;
    $display("FAIL %s timeout", nm);
  endtask

  task automatic tick;
    @(posedge ACLK);
    #1;
  endtask

  // monitor: compare on every B/R handshake
  always @(negedge ACLK) begin
    if (ARESETN) begin
      if (S_AXI.BVALID && S_AXI.BREADY) begin
        if (bq.size() == 0) tmo("b_unexpected");
        else chk("bresp", {62'b0, S_AXI.BRESP}, {62'b0, bq.pop_front()});
      end
      if (S_AXI.RVALID && S_AXI.RREADY) begin
        if (rq.size() == 0) tmo("r_unexpected");
        else begin
          rexp_t e;
          e = rq.pop_front();
          chk("rresp", {62'b0, S_AXI.RRESP}, {62'b0, e.resp});
          chk("rdata", {32'b0, S_AXI.RDATA}, {32'b0, e.data});
        end
      end
    end
  end

  // lead > 0: W leads AW by lead cycles; lead < 0: AW leads W
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input int lead, input logic [1:0] er);
    bit awd = 0, wd = 0, awhs, whs;
    int n = 0;
    bq.push_back(er);
    S_AXI.AWADDR  = a;
    S_AXI.WDATA   = d;
    S_AXI.WSTRB   = s;
    S_AXI.AWVALID = (lead <= 0);
    S_AXI.WVALID  = (lead >= 0);
    while (!(awd && wd) && n < 100) begin
      awhs = S_AXI.AWVALID && S_AXI.AWREADY;
      whs  = S_AXI.WVALID && S_AXI.WREADY;
      tick;
      n++;
      if (awhs) begin awd = 1; S_AXI.AWVALID = 1'b0; end
      if (whs)  begin wd = 1;  S_AXI.WVALID  = 1'b0; end
      if (!awd && !S_AXI.AWVALID && n >= lead)  S_AXI.AWVALID = 1'b1;
      if (!wd  && !S_AXI.WVALID  && n >= -lead) S_AXI.WVALID  = 1'b1;
    end
    if (n >= 100) tmo("wr_addr_data");
    chk("wr_bvalid_lat", {63'b0, S_AXI.BVALID}, 64'd1);
    n = 0;
    while (!(S_AXI.BVALID && S_AXI.BREADY) && n < 50) begin tick; n++; end
    if (n >= 50) tmo("wr_bresp");
    tick;
  endtask

  task automatic rd(input logic [31:0] a, input logic [1:0] er, input logic [31:0] ed,
                    input int stall);
    rexp_t e;
    int n = 0;
    e.resp = er;
    e.data = ed;
    rq.push_back(e);
    S_AXI.ARADDR  = a;
    S_AXI.ARVALID = 1'b1;
    while (!S_AXI.ARREADY && n < 50) begin tick; n++; end
    if (n >= 50) tmo("rd_ar");
    tick;
    S_AXI.ARVALID = 1'b0;
    if (stall > 0) begin
      S_AXI.RREADY = 1'b0;
      for (int i = 0; i < stall; i++) begin
        chk("rd_hold_rvalid",  {63'b0, S_AXI.RVALID},  64'd1);
        chk("rd_hold_arready", {63'b0, S_AXI.ARREADY}, 64'd0);
        chk("rd_hold_rdata",   {32'b0, S_AXI.RDATA},   {32'b0, ed});
        tick;
      end
      S_AXI.RREADY = 1'b1;
    end
    n = 0;
    while (!S_AXI.RVALID && n < 50) begin tick; n++; end
    if (n >= 50) tmo("rd_r");
    tick;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    ARESETN = 1'b0;
    S_AXI.ARADDR = '0; S_AXI.ARVALID = 1'b0; S_AXI.RREADY = 1'b1;
    S_AXI.AWADDR = '0; S_AXI.AWVALID = 1'b0;
    S_AXI.WDATA = '0; S_AXI.WSTRB = '0; S_AXI.WVALID = 1'b0; S_AXI.BREADY = 1'b1;
    CONFIG_READY = 2'b00;
    repeat (3) tick;
    ARESETN = 1'b1;

    chk("rst_awready", {63'b0, S_AXI.AWREADY}, 64'd1);
    chk("rst_wready",  {63'b0, S_AXI.WREADY},  64'd1);
    chk("rst_arready", {63'b0, S_AXI.ARREADY}, 64'd1);
    chk("rst_bvalid",  {63'b0, S_AXI.BVALID},  64'd0);
    chk("rst_rvalid",  {63'b0, S_AXI.RVALID},  64'd0);
    chk("rst_cvalid",  {62'b0, CONFIG_VALID},  64'd0);
    chk("rst_irq",     {63'b0, CONFIG_IRQ},    64'd0);
    chk("rst_cdata",   CONFIG_DATA[63:0],      64'd0);

    // AW+W together
    wr(32'h004, 32'hDEADBEEF, 4'hF, 0, RESP_OKAY);
    chk("t1_cdata", {32'b0, CONFIG_DATA[31:0]}, 64'hDEADBEEF);

    // W leads, single byte lane
    wr(32'h108, 32'h11223344, 4'hF, 0, RESP_OKAY);
    wr(32'h108, 32'h0000AB00, 4'b0010, 3, RESP_OKAY);
    chk("t2_strb", {32'b0, CONFIG_DATA[159:128]}, 64'h1122AB44);
    rd(32'h108, RESP_OKAY, 32'h1122AB44, 0);

    // AW leads
    wr(32'h00C, 32'hCAFEF00D, 4'hF, -2, RESP_OKAY);
    chk("t2_awlead", {32'b0, CONFIG_DATA[95:64]}, 64'hCAFEF00D);

    // decode errors: reg >= NREG, ch >= NCH, base mismatch; all dropped
    wr(32'h010, 32'h55555555, 4'hF, 0, RESP_SLVERR);
    wr(32'h204, 32'h66666666, 4'hF, 0, RESP_SLVERR);
    wr(32'h1000_0004, 32'h77777777, 4'hF, 0, RESP_SLVERR);
    rd(32'h004, RESP_OKAY, 32'hDEADBEEF, 0);
    rd(32'h1000_0004, RESP_SLVERR, 32'h0, 0);

    // launch ch0 and hold READY low
    wr(32'h000, 32'h1, 4'hF, 0, RESP_OKAY);
    chk("t3_valid", {62'b0, CONFIG_VALID}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("t3_valid_hold", {62'b0, CONFIG_VALID}, 64'd1);
    end
    CONFIG_READY = 2'b01;
    tick;
    CONFIG_READY = 2'b00;
    chk("t3_valid_drop", {62'b0, CONFIG_VALID}, 64'd0);
    rd(32'h000, RESP_OKAY, 32'h2, 0);

    // relaunch while busy and out-of-range channel read
    wr(32'h000, 32'h1, 4'hF, 0, RESP_SLVERR);
    chk("t4_no_valid", {62'b0, CONFIG_VALID}, 64'd0);
    rd(32'h300, RESP_SLVERR, 32'h0, 0);

    CONFIG_READY = 2'b01;
    tick;
    CONFIG_READY = 2'b00;
    chk("t3_irq", {63'b0, CONFIG_IRQ}, 64'd1);
    rd(32'h000, RESP_OKAY, 32'h4, 0);
    wr(32'h000, 32'h2, 4'hF, 0, RESP_OKAY);
    chk("t3_irq_clr", {63'b0, CONFIG_IRQ}, 64'd0);
    rd(32'h000, RESP_OKAY, 32'h0, 0);

    // launch without byte 0 enabled is ignored
    wr(32'h000, 32'h1, 4'b1110, 0, RESP_OKAY);
    chk("t3_strb0_ign", {62'b0, CONFIG_VALID}, 64'd0);

    // stalled reads
    rd(32'h004, RESP_OKAY, 32'hDEADBEEF, 4);
    rd(32'h108, RESP_OKAY, 32'h1122AB44, 4);

`ifdef CONF_PERF_CNT_EN
    // 8 PEND cycles + 1 handshake + 1 BUSY cycle = 10
    wr(32'h100, 32'h1, 4'hF, 0, RESP_OKAY);
    chk("t6_valid", {62'b0, CONFIG_VALID}, 64'd2);
    repeat (7) tick;
    CONFIG_READY = 2'b10;
    tick;
    tick;
    CONFIG_READY = 2'b00;
    chk("t6_irq", {63'b0, CONFIG_IRQ}, 64'd1);
    rd(32'h1FC, RESP_OKAY, 32'd10, 0);
    wr(32'h0FC, 32'h1234, 4'hF, 0, RESP_SLVERR);
`else
    rd(32'h0FC, RESP_SLVERR, 32'h0, 0);
    wr(32'h0FC, 32'h1234, 4'hF, 0, RESP_SLVERR);
`endif

    // reset with a read response outstanding
    S_AXI.ARADDR  = 32'h004;
    S_AXI.ARVALID = 1'b1;
    S_AXI.RREADY  = 1'b0;
    tick;
    S_AXI.ARVALID = 1'b0;
    chk("mid_rvalid", {63'b0, S_AXI.RVALID}, 64'd1);
    ARESETN = 1'b0;
    tick;
    tick;
    ARESETN = 1'b1;
    chk("mid_rst_rvalid",  {63'b0, S_AXI.RVALID},  64'd0);
    chk("mid_rst_arready", {63'b0, S_AXI.ARREADY}, 64'd1);
    chk("mid_rst_cdata",   {32'b0, CONFIG_DATA[31:0]}, 64'd0);
    chk("mid_rst_irq",     {63'b0, CONFIG_IRQ}, 64'd0);
    S_AXI.RREADY = 1'b1;
    repeat (2) tick;

    chk("bq_drained", 64'(bq.size()), 64'd0);
    chk("rq_drained", 64'(rq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
